// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder/subtractor cell plus a
// carry/borrow register, LSB first, with a start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             mode_r, carry, acc;
    logic [CW-1:0]    cnt;

    logic ai, bi, m1, s, c_nx, accept, last;

    // Inverting ai under subtract turns the carry term into a borrow term.
    always_comb begin
        ai     = a_sh[0];
        bi     = b_sh[0];
        m1     = mode_r ^ ai;
        s      = ai ^ bi ^ carry;
        c_nx   = (m1 & bi) | (m1 & carry) | (bi & carry);
        accept = start && (state == S_IDLE || state == S_DONE);
        last   = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            mode_r <= 1'b0;
            carry  <= 1'b0;
            acc    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_r <= mode;
            carry  <= cin;
            cnt    <= '0;
            acc    <= 1'b0;
            ovf    <= 1'b0;
            state  <= S_RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (state == S_RUN) begin
            result <= {s, result[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_nx;
            acc    <= acc | s;
            cnt    <= cnt + CW'(1);
            // MSB step: overflow is carry into the MSB xor carry out of it.
            if (last) begin
                ovf   <= carry ^ c_nx;
                cout  <= c_nx;
                zero  <= ~(acc | s);
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            state <= S_IDLE;
            done  <= 1'b0;
        end
    end
endmodule
